// File: rtl/turn_sequencer_if.sv
// Handshake bundle between the turn sequencer, the shared dice unit and the
// per-player position units.
interface turn_sequencer_if #(
  parameter int NUM_PLAYERS = 2
);
  logic                     roll_req;
  logic                     roll_valid;
  logic [2:0]               roll;
  logic [NUM_PLAYERS-1:0]   move_en;
  logic [2:0]               move_roll;
  logic                     move_done;
  logic [7*NUM_PLAYERS-1:0] pos_flat;

  modport master (
    output roll_req, move_en, move_roll,
    input  roll_valid, roll, move_done, pos_flat
  );

  modport slave (
    input  roll_req, move_en, move_roll,
    output roll_valid, roll, move_done, pos_flat
  );
endinterface

// File: rtl/turn_sequencer.sv
// Snakes-and-ladders game controller: requests a shared die roll, strobes the
// current player's position unit, checks for a win and advances the turn.
module turn_sequencer #(
  parameter int NUM_PLAYERS = 2,
  parameter int WIN_POS     = 99,
  parameter int MAX_SIXES   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  turn_sequencer_if.master bus,
  output logic [1:0]       turn,
  output logic             busy,
  output logic             game_over,
  output logic [1:0]       winner
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_MOVE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  localparam logic [1:0]             LAST_PLAYER = 2'(NUM_PLAYERS - 1);
  localparam logic [6:0]             WIN_SQUARE  = 7'(WIN_POS);
  localparam logic [2:0]             SIXES_LIMIT = 3'(MAX_SIXES);
  localparam logic [NUM_PLAYERS-1:0] ONE_HOT0    = NUM_PLAYERS'(1);

  state_t     state;
  logic [2:0] six_cnt;
  logic [2:0] six_next;
  logic [1:0] next_turn;
  logic [6:0] pos_arr [4];

  // Four slots so the 2-bit turn index always selects a real entry.
  for (genvar g = 0; g < 4; g++) begin : g_pos
    if (g < NUM_PLAYERS) begin : g_used
      assign pos_arr[g] = bus.pos_flat[7*g +: 7];
    end else begin : g_unused
      assign pos_arr[g] = '0;
    end
  end

  assign six_next  = six_cnt + 3'd1;
  assign next_turn = (turn == LAST_PLAYER) ? 2'd0 : turn + 2'd1;

  // NOTE: state registers use non-blocking assignments so every branch sees
  // the values from before this clock edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      bus.roll_req  <= 1'b0;
      bus.move_en   <= '0;
      bus.move_roll <= '0;
      turn          <= '0;
      busy          <= 1'b0;
      game_over     <= 1'b0;
      winner        <= '0;
      six_cnt       <= '0;
    end else begin
      bus.move_en <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_REQ;
            turn  <= '0;
            busy  <= 1'b1;
          end
        end
        S_REQ: begin
          // A dropped request re-asserts one cycle later, also after discarded rolls.
          if (!bus.roll_req) begin
            bus.roll_req <= 1'b1;
          end else if (bus.roll_valid) begin
            bus.roll_req <= 1'b0;
            if (bus.roll inside {[3'd1:3'd6]}) begin
              if (bus.roll == 3'd6 && six_next == SIXES_LIMIT) begin
                six_cnt <= '0;
                turn    <= next_turn;
              end else begin
                six_cnt       <= (bus.roll == 3'd6) ? six_next : 3'd0;
                bus.move_roll <= bus.roll;
                bus.move_en   <= ONE_HOT0 << turn;
                state         <= S_MOVE;
              end
            end
          end
        end
        S_MOVE: state <= S_WAIT;
        S_WAIT: begin
          if (bus.move_done) state <= S_CHECK;
        end
        S_CHECK: begin
          if (pos_arr[turn] == WIN_SQUARE) begin
            game_over <= 1'b1;
            winner    <= turn;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            if (bus.move_roll != 3'd6) begin
              turn    <= next_turn;
              six_cnt <= '0;
            end
            state <= S_REQ;
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: a 2-player and a 3-player instance share
// the dice and move-done stimulus; each has its own position bus.
module tb_turn_sequencer;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        start      = 1'b0;
  logic        roll_valid = 1'b0;
  logic [2:0]  roll       = 3'd0;
  logic        move_done  = 1'b0;
  logic [13:0] pos2       = '0;
  logic [20:0] pos3       = '0;

  logic [1:0] turn2, winner2, turn3, winner3;
  logic       busy2, go2, busy3, go3;

  int total = 0;
  int bad   = 0;

  turn_sequencer_if #(.NUM_PLAYERS(2)) if2 ();
  turn_sequencer_if #(.NUM_PLAYERS(3)) if3 ();

  assign if2.roll_valid = roll_valid;
  assign if2.roll       = roll;
  assign if2.move_done  = move_done;
  assign if2.pos_flat   = pos2;
  assign if3.roll_valid = roll_valid;
  assign if3.roll       = roll;
  assign if3.move_done  = move_done;
  assign if3.pos_flat   = pos3;

  turn_sequencer #(.NUM_PLAYERS(2), .WIN_POS(99), .MAX_SIXES(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(if2),
    .turn(turn2), .busy(busy2), .game_over(go2), .winner(winner2)
  );

  turn_sequencer #(.NUM_PLAYERS(3), .WIN_POS(99), .MAX_SIXES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(if3),
    .turn(turn3), .busy(busy3), .game_over(go3), .winner(winner3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; start = 1'b0; roll_valid = 1'b0; roll = 3'd0; move_done = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for roll_req, then presents v for one cycle; returns in
  // the cycle after the acceptance edge.
  task automatic serve_roll(input logic [2:0] v);
    int n = 0;
    while (if2.roll_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (if2.roll_req !== 1'b1) begin
      bad++;
      $display("FAIL roll_req_timeout got=%b want=1", if2.roll_req);
    end
    roll_valid = 1'b1; roll = v;
    step();
    roll_valid = 1'b0; roll = 3'd0;
  endtask

  // From the move_en cycle: move_done one cycle later, returns after CHECK.
  task automatic finish_move();
    step();
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (if2.roll_req !== 1'b0) begin bad++; $display("FAIL rst_roll_req got=%b want=0", if2.roll_req); end
    total++; if (if2.move_en !== 2'b00) begin bad++; $display("FAIL rst_move_en got=%b want=00", if2.move_en); end
    total++; if (if2.move_roll !== 3'd0) begin bad++; $display("FAIL rst_move_roll got=%0d want=0", if2.move_roll); end
    total++; if (turn2 !== 2'd0 || busy2 !== 1'b0) begin bad++; $display("FAIL rst_turn_busy got=%0d/%b want=0/0", turn2, busy2); end
    total++; if (go2 !== 1'b0 || winner2 !== 2'd0) begin bad++; $display("FAIL rst_win got=%b/%0d want=0/0", go2, winner2); end
    total++; if (if3.move_en !== 3'b000 || turn3 !== 2'd0 || busy3 !== 1'b0) begin bad++; $display("FAIL rst_dut3 got=%b/%0d/%b want=000/0/0", if3.move_en, turn3, busy3); end
  endtask

  task automatic test_basic_turn();
    apply_reset();
    pulse_start();
    total++; if (busy2 !== 1'b1 || turn2 !== 2'd0) begin bad++; $display("FAIL start_busy got=%b/%0d want=1/0", busy2, turn2); end
    total++; if (if2.roll_req !== 1'b0) begin bad++; $display("FAIL req_entry got=%b want=0", if2.roll_req); end
    serve_roll(3'd4);
    total++; if (if2.move_en !== 2'b01) begin bad++; $display("FAIL basic_move_en got=%b want=01", if2.move_en); end
    total++; if (if2.move_roll !== 3'd4) begin bad++; $display("FAIL basic_move_roll got=%0d want=4", if2.move_roll); end
    step();
    total++; if (if2.move_en !== 2'b00 || busy2 !== 1'b1) begin bad++; $display("FAIL basic_pulse_width got=%b/%b want=00/1", if2.move_en, busy2); end
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    total++; if (turn2 !== 2'd0 || busy2 !== 1'b1) begin bad++; $display("FAIL basic_check_turn got=%0d/%b want=0/1", turn2, busy2); end
    step();
    total++; if (turn2 !== 2'd1 || busy2 !== 1'b1) begin bad++; $display("FAIL basic_next_turn got=%0d/%b want=1/1", turn2, busy2); end
    total++; if (if2.roll_req !== 1'b0) begin bad++; $display("FAIL basic_req_reentry got=%b want=0", if2.roll_req); end
    step();
    total++; if (if2.roll_req !== 1'b1) begin bad++; $display("FAIL basic_req_rise got=%b want=1", if2.roll_req); end
    pulse_start();
    total++; if (turn2 !== 2'd1 || busy2 !== 1'b1) begin bad++; $display("FAIL busy_start_ignored got=%0d/%b want=1/1", turn2, busy2); end
  endtask

  task automatic test_early_done();
    apply_reset();
    pulse_start();
    serve_roll(3'd2);
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    step();
    step();
    step();
    total++; if (turn2 !== 2'd0 || busy2 !== 1'b1 || if2.roll_req !== 1'b0) begin bad++; $display("FAIL early_done_ignored got=%0d/%b/%b want=0/1/0", turn2, busy2, if2.roll_req); end
    move_done = 1'b1;
    step();
    move_done = 1'b0;
    step();
    total++; if (turn2 !== 2'd1) begin bad++; $display("FAIL late_done_turn got=%0d want=1", turn2); end
  endtask

  task automatic test_three_players();
    logic [2:0] exp_en   [3] = '{3'b001, 3'b010, 3'b100};
    logic [1:0] exp_turn [3] = '{2'd1, 2'd2, 2'd0};
    apply_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      serve_roll(3'(i + 1));
      total++; if (if3.move_en !== exp_en[i]) begin bad++; $display("FAIL p3_move_en[%0d] got=%b want=%b", i, if3.move_en, exp_en[i]); end
      finish_move();
      total++; if (turn3 !== exp_turn[i]) begin bad++; $display("FAIL p3_turn[%0d] got=%0d want=%0d", i, turn3, exp_turn[i]); end
    end
  endtask

  task automatic test_sixes();
    apply_reset();
    pulse_start();
    serve_roll(3'd6);
    total++; if (if2.move_en !== 2'b01) begin bad++; $display("FAIL six_first_move got=%b want=01", if2.move_en); end
    finish_move();
    total++; if (turn2 !== 2'd0) begin bad++; $display("FAIL six_extra_turn got=%0d want=0", turn2); end
    serve_roll(3'd2);
    total++; if (if2.move_en !== 2'b01) begin bad++; $display("FAIL six_then_two got=%b want=01", if2.move_en); end
    finish_move();
    total++; if (turn2 !== 2'd1) begin bad++; $display("FAIL six_then_two_turn got=%0d want=1", turn2); end
    serve_roll(3'd1);
    finish_move();
    for (int i = 0; i < 2; i++) begin
      serve_roll(3'd6);
      total++; if (if2.move_en !== 2'b01) begin bad++; $display("FAIL sixes_move[%0d] got=%b want=01", i, if2.move_en); end
      finish_move();
    end
    serve_roll(3'd6);
    total++; if (if2.move_en !== 2'b00 || turn2 !== 2'd1) begin bad++; $display("FAIL third_six got=%b/%0d want=00/1", if2.move_en, turn2); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (if2.move_en !== 2'b00) begin bad++; $display("FAIL third_six_quiet[%0d] got=%b want=00", i, if2.move_en); end
    end
    serve_roll(3'd6);
    total++; if (if2.move_en !== 2'b10) begin bad++; $display("FAIL six_cnt_cleared got=%b want=10", if2.move_en); end
    finish_move();
    total++; if (turn2 !== 2'd1) begin bad++; $display("FAIL p1_extra_turn got=%0d want=1", turn2); end
  endtask

  task automatic test_invalid_rolls();
    apply_reset();
    pulse_start();
    serve_roll(3'd0);
    total++; if (if2.move_en !== 2'b00 || if2.roll_req !== 1'b0) begin bad++; $display("FAIL roll0_drop got=%b/%b want=00/0", if2.move_en, if2.roll_req); end
    step();
    total++; if (if2.roll_req !== 1'b1) begin bad++; $display("FAIL roll0_rereq got=%b want=1", if2.roll_req); end
    serve_roll(3'd7);
    total++; if (if2.move_en !== 2'b00) begin bad++; $display("FAIL roll7_discard got=%b want=00", if2.move_en); end
    serve_roll(3'd3);
    total++; if (if2.move_en !== 2'b01 || if2.move_roll !== 3'd3) begin bad++; $display("FAIL roll3_move got=%b/%0d want=01/3", if2.move_en, if2.move_roll); end
    finish_move();
    serve_roll(3'd1);
    finish_move();
    serve_roll(3'd6);
    finish_move();
    serve_roll(3'd0);
    serve_roll(3'd7);
    serve_roll(3'd6);
    total++; if (if2.move_en !== 2'b01) begin bad++; $display("FAIL second_six_move got=%b want=01", if2.move_en); end
    finish_move();
    serve_roll(3'd6);
    total++; if (if2.move_en !== 2'b00 || turn2 !== 2'd1) begin bad++; $display("FAIL invalid_keep_cnt got=%b/%0d want=00/1", if2.move_en, turn2); end
  endtask

  task automatic test_win();
    apply_reset();
    pos2 = {7'd99, 7'd98};
    pulse_start();
    serve_roll(3'd2);
    finish_move();
    total++; if (go2 !== 1'b0 || turn2 !== 2'd1) begin bad++; $display("FAIL pos98_no_win got=%b/%0d want=0/1", go2, turn2); end
    serve_roll(3'd5);
    finish_move();
    total++; if (go2 !== 1'b1 || winner2 !== 2'd1 || busy2 !== 1'b0) begin bad++; $display("FAIL win_flags got=%b/%0d/%b want=1/1/0", go2, winner2, busy2); end
    start = 1'b1; roll_valid = 1'b1; roll = 3'd3; move_done = 1'b1;
    for (int i = 0; i < 4; i++) step();
    start = 1'b0; roll_valid = 1'b0; roll = 3'd0; move_done = 1'b0;
    total++; if (if2.roll_req !== 1'b0 || if2.move_en !== 2'b00 || if2.move_roll !== 3'd5) begin bad++; $display("FAIL done_frozen_bus got=%b/%b/%0d want=0/00/5", if2.roll_req, if2.move_en, if2.move_roll); end
    total++; if (go2 !== 1'b1 || winner2 !== 2'd1 || busy2 !== 1'b0 || turn2 !== 2'd1) begin bad++; $display("FAIL done_frozen got=%b/%0d/%b/%0d want=1/1/0/1", go2, winner2, busy2, turn2); end
    pos2 = '0;
  endtask

  task automatic test_reset_mid_turn();
    apply_reset();
    pulse_start();
    serve_roll(3'd1);
    finish_move();
    serve_roll(3'd4);
    step();
    reset_n = 1'b0;
    #1;
    total++; if (turn2 !== 2'd0 || busy2 !== 1'b0 || if2.move_roll !== 3'd0) begin bad++; $display("FAIL async_rst got=%0d/%b/%0d want=0/0/0", turn2, busy2, if2.move_roll); end
    total++; if (if2.roll_req !== 1'b0 || if2.move_en !== 2'b00 || go2 !== 1'b0 || winner2 !== 2'd0) begin bad++; $display("FAIL async_rst_bus got=%b/%b/%b/%0d want=0/00/0/0", if2.roll_req, if2.move_en, go2, winner2); end
    move_done = 1'b1;
    step();
    step();
    move_done = 1'b0;
    reset_n = 1'b1;
    step();
    total++; if (if2.move_en !== 2'b00 || busy2 !== 1'b0) begin bad++; $display("FAIL rst_release_idle got=%b/%b want=00/0", if2.move_en, busy2); end
    pulse_start();
    total++; if (turn2 !== 2'd0 || busy2 !== 1'b1) begin bad++; $display("FAIL fresh_game got=%0d/%b want=0/1", turn2, busy2); end
    serve_roll(3'd3);
    total++; if (if2.move_en !== 2'b01 || if2.move_roll !== 3'd3) begin bad++; $display("FAIL fresh_move got=%b/%0d want=01/3", if2.move_en, if2.move_roll); end
  endtask

  initial begin
    test_reset();
    test_basic_turn();
    test_early_done();
    test_three_players();
    test_sixes();
    test_invalid_rolls();
    test_win();
    test_reset_mid_turn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Central game controller for the snakes-and-ladders board.
- Runs the turn loop for 2-4 players: requests a die roll, validates it, strobes the current player's position unit, checks for a win, then advances the turn.
- Replaces free-running per-player dice with a single shared die and an explicit handshake.
- Sits between the dice unit and the player position registers in the top level.

Parameters:
- NUM_PLAYERS, 2, number of players (legal range 2..4).
- WIN_POS, 99, board square that ends the game.
- MAX_SIXES, 3, number of consecutive sixes that forfeits the turn.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a game from IDLE.
- roll_req  output  1  request to the dice unit.
- roll_valid  input  1  dice unit result valid.
- roll  input  3  dice value; legal values 1..6.
- move_en  output  NUM_PLAYERS  one-hot move strobe, one bit per player.
- move_roll  output  3  validated roll presented with move_en.
- move_done  input  1  the addressed player unit has updated its position.
- pos_flat  input  7*NUM_PLAYERS  player positions; player i occupies bits [7i+6:7i].
- turn  output  2  index of the current player.
- busy  output  1  high in every state except IDLE and DONE.
- game_over  output  1  sticky win flag.
- winner  output  2  index of the winning player; valid when game_over=1.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; roll_req=0, move_en=0, move_roll=0, turn=0, busy=0, game_over=0, winner=0; six counter=0.
- States: IDLE, REQ, MOVE, WAIT, CHECK, DONE.
- IDLE: on start=1 go to REQ; turn=0.
- REQ:
  - roll_req held high until a cycle with roll_valid=1.
  - roll is sampled in that same cycle; roll_req drops the next cycle.
  - roll of 0 or 7: discarded; stay in REQ, roll_req re-asserts the following cycle. Six counter unchanged.
  - roll 1..5: six counter cleared; go to MOVE.
  - roll=6: six counter increments.
    - If the new count is below MAX_SIXES: go to MOVE.
    - If the new count equals MAX_SIXES: no move; six counter cleared; turn advances; go to REQ.
- MOVE:
  - move_en[turn]=1 for exactly one cycle; move_roll=the sampled roll, held until the next REQ acceptance.
  - Go to WAIT.
- WAIT:
  - Wait for move_done=1; no timeout.
  - move_done arriving in the same cycle as the move_en pulse is not accepted; only cycles after MOVE count.
- CHECK (one cycle, evaluated on pos_flat of the current player):
  - Position == WIN_POS: game_over=1, winner=turn; go to DONE.
  - Otherwise, if the last roll was 6: extra turn; turn unchanged; go to REQ.
  - Otherwise: turn = (turn==NUM_PLAYERS-1) ? 0 : turn+1; six counter cleared; go to REQ.
- DONE: outputs frozen; start ignored; exit only via reset_n.
- start while busy=1 is ignored.
- roll_valid outside REQ is ignored.
- move_done outside WAIT is ignored.
- Latency from roll acceptance to move_en: 1 cycle. Normal turn with move_done returned 1 cycle after move_en: 5 cycles REQ-to-REQ.
- Reset asserted mid-turn aborts immediately: all outputs return to reset values and no move_en pulse follows.
- Width rules:
  - turn wraps modulo NUM_PLAYERS, never modulo 4.
  - Unused move_en bits do not exist; port width equals NUM_PLAYERS.
  - The position compare is a 7-bit unsigned equality.

Test Plan:
- Reset, start, roll=4, move_done 1 cycle after move_en=01 -> move_roll=4; turn 0->1 after CHECK; busy=1 throughout.
- NUM_PLAYERS=3 with three non-six turns -> turn sequence 0,1,2,0; move_en sequence 001,010,100.
- Player 0 rolls 6 then 2 -> two move_en pulses to player 0, then turn=1. Player 0 rolls 6,6,6 -> two moves, third six gives no move_en and turn=1.
- roll=0 then roll=7 then roll=3 -> two re-requests, a single move_en with move_roll=3; six counter unaffected.
- pos_flat shows player 1 at 99 after its move -> game_over=1, winner=1, busy=0; later start and roll_valid pulses change nothing.
- reset_n pulsed low during WAIT -> all outputs zero asynchronously; a start pulse after release begins a fresh game with turn=0.
